// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and
// the alignment rule used to reject an access before it touches memory.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STORE,
      RMW_RD,
      RMW_WR,
      RESP
   } state_t;

   // Reserved size, odd half address or non-word-aligned word address.
   function automatic logic access_err(input logic [1:0] size, input logic [1:0] offset);
      logic err;
      case (size)
         SZ_BYTE: err = 1'b0;
         SZ_HALF: err = offset[0];
         SZ_WORD: err = (offset != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane extraction with sign/zero extension, and the byte/half merge
// used by read-modify-write stores. Purely combinational.
module lsu_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [4:0]         sh;
   logic signed [7:0]  lane_b;
   logic signed [15:0] lane_h;
   logic [31:0]        mask;
   logic [31:0]        ins;

   always_comb begin
      // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
      sh        = (size == SZ_HALF) ? {~offset[1], 4'b0000} : {~offset, 3'b000};
      lane_b    = 8'(rdata >> sh);
      lane_h    = 16'(rdata >> sh);
      load_data = rdata;
      mask      = 32'hFFFF_FFFF;
      ins       = wdata;
      case (size)
         SZ_BYTE: begin
            load_data = is_unsigned ? {24'h0, lane_b} : 32'(lane_b);
            mask      = 32'h0000_00FF << sh;
            ins       = {24'h0, wdata[7:0]} << sh;
         end
         SZ_HALF: begin
            load_data = is_unsigned ? {16'h0, lane_h} : 32'(lane_h);
            mask      = 32'h0000_FFFF << sh;
            ins       = {16'h0, wdata[15:0]} << sh;
         end
         default: ;
      endcase
      merged = (rdata & ~mask) | (ins & mask);
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline request/response handshake and a
// single-port word memory; sub-word stores are done as read-modify-write.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_t                state, state_nxt;
   logic                  accept;
   logic                  req_err;

   logic [1:0]            size_q;
   logic                  uns_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] merge_q;
   logic                  err_q;

   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] merged;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];
   assign accept         = req_valid && (state == IDLE);
   assign req_err        = access_err(req_size, req_addr[1:0]);

   lsu_align u_align (
      .rdata       (mem_rdata),
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)               state_nxt = RESP;
               else if (!req_we)          state_nxt = LOAD;
               else if (req_size == SZ_WORD) state_nxt = STORE;
               else                       state_nxt = RMW_RD;
            end
         end
         LOAD:    state_nxt = RESP;
         STORE:   state_nxt = RESP;
         RMW_RD:  state_nxt = RMW_WR;
         RMW_WR:  state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Every output is decoded from state, so the async reset clears them at once.
   always_comb begin
      req_ready  = (state == IDLE);
      mem_read   = (state == LOAD) || (state == RMW_RD);
      mem_write  = (state == STORE) || (state == RMW_WR);
      mem_addr   = (mem_read || mem_write) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
      mem_wdata  = '0;
      if (state == STORE)  mem_wdata = wdata_q;
      if (state == RMW_WR) mem_wdata = merge_q;
      resp_valid = (state == RESP);
      resp_err   = (state == RESP) && err_q;
      resp_rdata = (state == RESP) ? rdata_q : '0;
   end

   // Datapath registers carry no reset; they are only observed through the gated outputs.
   always_ff @(posedge clk) begin
      if (accept) begin
         size_q  <= req_size;
         uns_q   <= req_unsigned;
         addr_q  <= req_addr[ADDR_WIDTH-1:0];
         wdata_q <= req_wdata;
         err_q   <= req_err;
         rdata_q <= '0;
      end
      if (state == LOAD)   rdata_q <= load_data;
      if (state == RMW_RD) merge_q <= merged;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-addressed big-endian
// reference memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] tb_mem [256];
   logic [7:0]  ref_bytes [1024];
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          both_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   assign mem_rdata = tb_mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_write) begin
         tb_mem[mem_addr[9:2]] <= mem_wdata;
         wr_cnt = wr_cnt + 1;
      end
      if (mem_read) rd_cnt = rd_cnt + 1;
      if (mem_read && mem_write) both_cnt = both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int a);
      int b;
      b = a & 32'h3FC;
      return {ref_bytes[b], ref_bytes[b+1], ref_bytes[b+2], ref_bytes[b+3]};
   endfunction

   // Issue one request at a negedge, follow it to completion, return at a negedge.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold);
      logic        e_err;
      logic [31:0] e_rdata;
      int          e_lat, e_rd, e_wr, n, a, lat;
      logic [31:0] v;
      n = 1 << sz;
      a = int'(addr & 32'h3FF);
      e_err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
      e_rdata = '0;
      if (e_err) begin
         e_lat = 1; e_rd = 0; e_wr = 0;
      end else if (!we) begin
         v = '0;
         for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_bytes[a+i]);
         if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         e_rdata = v;
         e_lat = 2; e_rd = 1; e_wr = 0;
      end else begin
         for (int i = 0; i < n; i++) ref_bytes[a+i] = 8'(wd >> (8*(n-1-i)));
         e_lat = (sz == 2'b10) ? 2 : 3;
         e_rd  = (sz == 2'b10) ? 0 : 1;
         e_wr  = 1;
      end

      rd_cnt = 0; wr_cnt = 0;
      req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      check("req_ready_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = $urandom;
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, e_lat);
      check("rdata", resp_rdata, e_rdata);
      check("err", 32'(resp_err), 32'(e_err));
      check("rd_pulses", rd_cnt, e_rd);
      check("wr_pulses", wr_cnt, e_wr);
      check("mem_idle_resp", {30'd0, mem_read, mem_write}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rdata", resp_rdata, e_rdata);
         check("hold_err", 32'(resp_err), 32'(e_err));
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("resp_done", 32'(resp_valid), 32'd0);
      check("ready_again", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] saved;
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         tb_mem[i] = w;
         {ref_bytes[4*i], ref_bytes[4*i+1], ref_bytes[4*i+2], ref_bytes[4*i+3]} = w;
      end

      #12;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp", {29'd0, resp_valid, resp_err, |resp_rdata}, 32'd0);
      check("rst_mem", {29'd0, mem_read, mem_write, |{mem_addr, mem_wdata}}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 0);
      check("word_store_mem", tb_mem[4], 32'h1234_5678);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_56F0, 0);
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 0);
      do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 0);
      check("half_store_mem", tb_mem[4], 32'h1234_BEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 0);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
      do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFF_FFFF, 2);

      // Reset while the read-modify-write is about to commit
      saved = tb_mem[8];
      req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h21; req_wdata = 32'hA5; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rmw_wr_reached", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_kills_write", 32'(mem_write), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mem_unchanged", tb_mem[8], saved);
      check("rst_mem_vs_ref", tb_mem[8], ref_word(32'h20));
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_no_resp", 32'(resp_valid), 32'd0);

      // Random traffic
      for (int t = 0; t < 400; t++) begin
         do_req(1'($urandom), 2'($urandom), 1'($urandom),
                ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)),
                $urandom, (($urandom & 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      for (int i = 0; i < 16; i++) check("final_mem", tb_mem[i], ref_word(4*i));
      check("never_rd_and_wr", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got=%0d exp=%0d", checks, 0);
      $fatal(1, "timeout");
   end

endmodule
